wall_pixel_fetch: RTL and testbench
===================================

// Module: wall_pixel_fetch
// PURPOSE
//   Upstream address stage for the wall sprite ROM. Takes the VGA controller's
//   pixel coordinates, tracks the wall tile row, and drives the ROM read
//   address. Registers the 4-bit palette index the ROM returns and emits it to
//   the colour mapper, aligned with delayed DrawX/DrawY and a valid flag.
// PARAMETERS
//   H_ACTIVE    640  active pixels per line
//   WALL_W      10   wall sprite width in pixels (left and right border strips)
//   TILE_H      10   wall sprite height; the sprite tiles vertically
//   RIGHT_BASE  629  ROM address of right-sprite entry 0
//   BLANK_ADDR  320  ROM address driven outside both strips; ROM returns 0
// PORTS
//   Clk          in   1   system clock; all logic is rising-edge
//   Reset_n      in   1   synchronous reset, active low
//   frame_start  in   1   1-cycle pulse, coincident with pixel (0,0) of a frame
//   pix_en       in   1   1 = active video (DrawX/DrawY are valid)
//   DrawX        in   10  current pixel column
//   DrawY        in   10  current pixel row
//   rom_data     in   4   palette index from the wall ROM (combinational read)
//   rom_addr     out  19  registered ROM read address
//   wall_idx     out  4   registered palette index; 0 when not a wall pixel
//   wall_hit     out  1   1 = wall_idx belongs to a wall strip pixel
//   pix_valid    out  1   pix_en delayed by 2 cycles and gated by state
//   DrawX_out    out  10  DrawX delayed by 2 cycles
//   DrawY_out    out  10  DrawY delayed by 2 cycles
// BEHAVIOUR
//   Reset (Reset_n=0 at an edge): state=WAIT_FRAME, trow=0, rom_addr=BLANK_ADDR.
//     wall_idx, wall_hit, pix_valid, DrawX_out and DrawY_out all clear to 0.
//     Pipeline contents are discarded. Reset mid-frame behaves the same way.
//   FSM: WAIT_FRAME -> RUN on frame_start. RUN stays in RUN.
//     In WAIT_FRAME: stage-1 valid is forced to 0 and rom_addr=BLANK_ADDR.
//     In RUN: a new frame_start re-synchronises the tile row.
//   Row counter trow (0..TILE_H-1):
//     eff_row = frame_start ? 0 : trow.
//     Next trow: frame_start -> 1 if it is also end-of-line, else 0. Frame
//     start has priority. Otherwise, at end-of-line (pix_en && DrawX==H_ACTIVE-1),
//     trow = (eff_row==TILE_H-1) ? 0 : eff_row+1. It holds at all other times.
//   Stage 1 (edge N+1, sampled at edge N), only when in RUN and pix_en=1:
//     DrawX <  WALL_W          : rom_addr = eff_row*WALL_W + DrawX;        s1_hit=1
//     DrawX >= H_ACTIVE-WALL_W : rom_addr = RIGHT_BASE + eff_row*WALL_W
//                                           + (DrawX-(H_ACTIVE-WALL_W)); s1_hit=1
//     otherwise, or pix_en=0   : rom_addr = BLANK_ADDR; s1_hit=0
//     s1_valid = pix_en && (state==RUN). Coordinates register alongside.
//     All address arithmetic is done at 19 bits, unsigned, with no wrap.
//   Stage 2 (edge N+2): wall_idx = s1_hit ? rom_data : 0; wall_hit = s1_hit.
//     pix_valid = s1_valid; DrawX_out/DrawY_out = stage-1 coordinates.
//   Latency: exactly 2 Clk cycles, input pixel to output.
//     One pixel per cycle, no stalls, no backpressure.
//   The frame_start edge that leaves WAIT_FRAME is itself processed as RUN,
//     so pixel (0,0) is not lost.
// TESTING
//   1. Reset_n=0 for 3 cycles, then 1, with no frame_start -> rom_addr=320,
//      pix_valid=0 and wall_hit=0 throughout.
//   2. frame_start with (0,0) pix_en=1 -> cycle+1: rom_addr=0;
//      cycle+2: wall_idx=rom_data, wall_hit=1, pix_valid=1, DrawX_out=0.
//   3. Line 3, DrawX=635 -> rom_addr = 629+30+5 = 664.
//      DrawX=320 -> rom_addr=320, wall_hit=0, wall_idx=0.
//   4. Run 10 full lines -> trow sequence 0..9 then 0. On line 10,
//      DrawX=2 -> rom_addr=2.
//   5. Drive pix_en=0 (blanking) with DrawX=5 -> rom_addr=320, pix_valid=0
//      two cycles later, trow unchanged.
//   6. Mid-line (trow=4), pulse Reset_n=0 for 1 cycle -> all outputs 0 and
//      WAIT_FRAME. Next frame_start -> rom_addr=0 at (0,0).

Source files
------------

// File: rtl/wall_pixel_fetch.sv
// Address stage for the wall sprite ROM: maps VGA pixel coordinates to a ROM
// read address, then registers the returned palette index two cycles later.
module wall_pixel_fetch #(
  parameter int H_ACTIVE   = 640,
  parameter int WALL_W     = 10,
  parameter int TILE_H     = 10,
  parameter int RIGHT_BASE = 629,
  parameter int BLANK_ADDR = 320,
  localparam int ROW_W     = $clog2(TILE_H)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_start,
  input  logic             pix_en,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [3:0]       rom_data,
  output logic [18:0]      rom_addr,
  output logic [3:0]       wall_idx,
  output logic             wall_hit,
  output logic             pix_valid,
  output logic [9:0]       DrawX_out,
  output logic [9:0]       DrawY_out,
  output logic [0:0]       dbg_state,
  output logic [ROW_W-1:0] dbg_trow
);

  typedef enum logic [0:0] {WAIT_FRAME = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   trow_q, trow_d;
  logic [18:0]        rom_addr_q, rom_addr_d;
  logic               s1_hit_q, s1_hit_d;
  logic               s1_valid_q, s1_valid_d;
  logic [9:0]         s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [3:0]         wall_idx_q, wall_idx_d;
  logic               wall_hit_q, wall_hit_d;
  logic               pix_valid_q, pix_valid_d;
  logic [9:0]         x_out_q, x_out_d, y_out_q, y_out_d;

  logic               in_run;
  logic               eol;
  logic [ROW_W-1:0]   eff_row;
  logic [18:0]        row_base;
  logic [18:0]        x19;

  always_comb begin
    state_d = state_q;
    if (frame_start) state_d = RUN;

    // The frame_start cycle itself counts as RUN so pixel (0,0) is fetched.
    in_run  = (state_q == RUN) || frame_start;
    eff_row = frame_start ? '0 : trow_q;
    eol     = pix_en && (DrawX == 10'(H_ACTIVE - 1));

    trow_d = trow_q;
    if (frame_start)
      trow_d = eol ? ROW_W'(1) : '0;
    else if (eol)
      trow_d = (eff_row == ROW_W'(TILE_H - 1)) ? '0 : eff_row + ROW_W'(1);

    row_base   = 19'(eff_row) * 19'(WALL_W);
    x19        = 19'(DrawX);
    rom_addr_d = 19'(BLANK_ADDR);
    s1_hit_d   = 1'b0;
    if (in_run && pix_en) begin
      if (x19 < 19'(WALL_W)) begin
        rom_addr_d = row_base + x19;
        s1_hit_d   = 1'b1;
      end else if (x19 >= 19'(H_ACTIVE - WALL_W)) begin
        rom_addr_d = 19'(RIGHT_BASE) + row_base + (x19 - 19'(H_ACTIVE - WALL_W));
        s1_hit_d   = 1'b1;
      end
    end
    s1_valid_d = pix_en && in_run;
    s1_x_d     = DrawX;
    s1_y_d     = DrawY;

    // rom_data is the combinational read of rom_addr_q, i.e. of stage 1.
    wall_idx_d  = s1_hit_q ? rom_data : 4'd0;
    wall_hit_d  = s1_hit_q;
    pix_valid_d = s1_valid_q;
    x_out_d     = s1_x_q;
    y_out_d     = s1_y_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= WAIT_FRAME;
      trow_q      <= '0;
      rom_addr_q  <= 19'(BLANK_ADDR);
      s1_hit_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      wall_idx_q  <= '0;
      wall_hit_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      trow_q      <= trow_d;
      rom_addr_q  <= rom_addr_d;
      s1_hit_q    <= s1_hit_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      wall_idx_q  <= wall_idx_d;
      wall_hit_q  <= wall_hit_d;
      pix_valid_q <= pix_valid_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign wall_idx  = wall_idx_q;
  assign wall_hit  = wall_hit_q;
  assign pix_valid = pix_valid_q;
  assign DrawX_out = x_out_q;
  assign DrawY_out = y_out_q;
  assign dbg_state = state_q;
  assign dbg_trow  = trow_q;

endmodule

// File: tb/tb_wall_pixel_fetch.sv
// Bench for wall_pixel_fetch: directed vector table, hand-written corner
// sequences and random pixels, all checked against a per-pixel reference model.
module tb_wall_pixel_fetch;

  logic        Clk;
  logic        Reset_n;
  logic        frame_start;
  logic        pix_en;
  logic [9:0]  DrawX, DrawY;
  logic [3:0]  rom_data;
  logic [18:0] rom_addr;
  logic [3:0]  wall_idx;
  logic        wall_hit, pix_valid;
  logic [9:0]  DrawX_out, DrawY_out;
  logic [0:0]  dbg_state;
  logic [3:0]  dbg_trow;

  int n_checks = 0;
  int n_errors = 0;

  wall_pixel_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_en(pix_en),
    .DrawX(DrawX), .DrawY(DrawY), .rom_data(rom_data), .rom_addr(rom_addr),
    .wall_idx(wall_idx), .wall_hit(wall_hit), .pix_valid(pix_valid),
    .DrawX_out(DrawX_out), .DrawY_out(DrawY_out), .dbg_state(dbg_state),
    .dbg_trow(dbg_trow)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM stub: every address yields a distinct-ish nonzero-biased index.
  function automatic logic [3:0] rom_fn(input logic [18:0] a);
    return a[3:0] ^ 4'hA;
  endfunction
  assign rom_data = rom_fn(rom_addr);

  // ---------------- reference model ----------------
  typedef struct {
    logic [18:0] addr;
    logic        hit;
    logic        valid;
    logic [9:0]  x;
    logic [9:0]  y;
  } rec_t;

  rec_t hist[$];
  bit   m_run = 1'b0;
  int   m_row = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pixel per cycle: drive, update model, clock, compare all outputs.
  task automatic step(input bit rst_n_v, input bit fs, input bit pe,
                      input int x, input int y);
    rec_t r;
    rec_t p;
    bit   run_eff;
    int   row_eff;
    @(negedge Clk);
    Reset_n     = rst_n_v;
    frame_start = fs;
    pix_en      = pe;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    if (!rst_n_v) begin
      r.addr = 19'd320; r.hit = 1'b0; r.valid = 1'b0; r.x = '0; r.y = '0;
      hist.delete();
      hist.push_back(r);
      hist.push_back(r);
      m_run = 1'b0;
      m_row = 0;
    end else begin
      run_eff = m_run || fs;
      row_eff = fs ? 0 : m_row;
      r.x = 10'(x); r.y = 10'(y);
      r.valid = run_eff && pe;
      r.hit = 1'b0; r.addr = 19'd320;
      if (run_eff && pe && x < 10) begin
        r.addr = 19'(row_eff * 10 + x); r.hit = 1'b1;
      end else if (run_eff && pe && x >= 630) begin
        r.addr = 19'(629 + row_eff * 10 + (x - 630)); r.hit = 1'b1;
      end
      if (fs) m_row = (pe && x == 639) ? 1 : 0;
      else if (pe && x == 639) m_row = (row_eff + 1) % 10;
      m_run = run_eff;
      hist.push_back(r);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    @(posedge Clk);
    #1;
    p = hist[0];
    chk("rom_addr",  32'(rom_addr),  32'(hist[1].addr));
    chk("wall_idx",  32'(wall_idx),  p.hit ? 32'(rom_fn(p.addr)) : 32'd0);
    chk("wall_hit",  32'(wall_hit),  32'(p.hit));
    chk("pix_valid", 32'(pix_valid), 32'(p.valid));
    chk("DrawX_out", 32'(DrawX_out), 32'(p.x));
    chk("DrawY_out", 32'(DrawY_out), 32'(p.y));
    chk("trow",      32'(dbg_trow),  32'(m_row));
    chk("state",     32'(dbg_state), 32'(m_run));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          fs;
    bit          pe;
    int          x;
    int          y;
    logic [18:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int saved_row;
    Reset_n = 1'b0; frame_start = 1'b0; pix_en = 1'b0; DrawX = '0; DrawY = '0;

    vecs.push_back('{1, 1,   0, 0, 19'd0});
    vecs.push_back('{0, 1,   5, 0, 19'd5});
    vecs.push_back('{0, 1, 639, 0, 19'd638});
    vecs.push_back('{0, 1, 639, 1, 19'd648});
    vecs.push_back('{0, 1, 639, 2, 19'd658});
    vecs.push_back('{0, 1, 635, 3, 19'd664});
    vecs.push_back('{0, 1, 320, 3, 19'd320});
    vecs.push_back('{0, 0,   5, 3, 19'd320});
    vecs.push_back('{0, 1,   9, 3, 19'd39});
    vecs.push_back('{0, 1,  10, 3, 19'd320});
    vecs.push_back('{0, 1, 629, 3, 19'd320});
    vecs.push_back('{0, 1, 630, 3, 19'd659});
    vecs.push_back('{1, 1, 639, 0, 19'd638});
    vecs.push_back('{0, 1,   3, 1, 19'd13});

    // Reset held 3 cycles, then idle in WAIT_FRAME with wall-strip pixels.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("rst_addr", 32'(rom_addr), 32'd320);
    for (int i = 0; i < 4; i++) step(1, 0, 1, i * 2, 0);
    chk("wait_addr", 32'(rom_addr), 32'd320);
    chk("wait_valid", 32'(pix_valid), 32'd0);

    foreach (vecs[i]) begin
      step(1, vecs[i].fs, vecs[i].pe, vecs[i].x, vecs[i].y);
      chk("table_addr", 32'(rom_addr), 32'(vecs[i].exp_addr));
    end

    // Ten full lines from a frame start, then the wrapped tile row.
    for (int l = 0; l < 10; l++) begin
      for (int x = 0; x < 640; x++) begin
        step(1, (l == 0 && x == 0), 1, x, l);
        if (x == 0) chk("trow_seq", 32'(dbg_trow), 32'(l));
      end
    end
    for (int x = 0; x < 6; x++) begin
      step(1, 0, 1, x, 10);
      if (x == 0) chk("trow_wrap", 32'(dbg_trow), 32'd0);
      if (x == 2) chk("line10_addr", 32'(rom_addr), 32'd2);
    end

    // Blanking: no fetch, no valid, and an x=639 blank pixel is not end-of-line.
    saved_row = int'(dbg_trow);
    step(1, 0, 0, 5, 10);
    chk("blank_addr", 32'(rom_addr), 32'd320);
    step(1, 0, 0, 639, 10);
    chk("blank_valid", 32'(pix_valid), 32'd0);
    chk("blank_trow", 32'(dbg_trow), 32'(saved_row));

    // Mid-line reset at tile row 4.
    step(1, 1, 1, 0, 0);
    for (int y = 0; y < 4; y++) step(1, 0, 1, 639, y);
    step(1, 0, 1, 100, 4);
    step(1, 0, 1, 3, 4);
    chk("row4_addr", 32'(rom_addr), 32'd43);
    step(0, 0, 1, 4, 4);
    chk("mrst_addr",  32'(rom_addr),  32'd320);
    chk("mrst_idx",   32'(wall_idx),  32'd0);
    chk("mrst_hit",   32'(wall_hit),  32'd0);
    chk("mrst_valid", 32'(pix_valid), 32'd0);
    chk("mrst_state", 32'(dbg_state), 32'd0);
    step(1, 1, 1, 0, 0);
    chk("refs_addr", 32'(rom_addr), 32'd0);
    step(1, 0, 1, 1, 0);
    chk("refs_hit", 32'(wall_hit), 32'd1);

    // Random pixels, occasional frame starts and resets.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      int x;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       x = int'($urandom_range(0, 9));
        1:       x = int'($urandom_range(630, 639));
        2:       x = 639;
        default: x = int'($urandom_range(0, 639));
      endcase
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 7) != 0),
           x, int'($urandom_range(0, 479)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
